// File: rtl/spike_rate_decoder_pkg.sv
// Shared constants and types for the spike rate decoder slice.
// Default sizing, saturation limit, handshake state encoding and the total-readout select code.
package spike_dec_pkg;

  localparam int unsigned N_CH_DEF     = 5;
  localparam int unsigned CNT_W_DEF    = 8;
  localparam int unsigned WIN_LOG2_DEF = 8;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX   = '1;
  localparam logic [2:0]           SEL_TOTAL = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } hs_state_e;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Spike input and rate readout bundle between the neuron array / host and the decoder.
// The master side drives spikes, enable, select and ack; the slave side returns the readout.
interface spike_rate_decoder_if
  import spike_dec_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             ena;
  logic [N_CH-1:0]  spike_in;
  logic [2:0]       sel;
  logic             rate_ack;
  logic [CNT_W-1:0] rate_out;
  logic             rate_valid;
  logic             window_done;
  logic             overrun;

  modport master (
    output ena, spike_in, sel, rate_ack,
    input  rate_out, rate_valid, window_done, overrun
  );

  modport slave (
    input  ena, spike_in, sel, rate_ack,
    output rate_out, rate_valid, window_done, overrun
  );
endinterface

// File: rtl/spike_rate_decoder_sat_counter.sv
// Saturating per-channel spike counter; sat_o is the incremented (clamped) value so the
// window-end snapshot can capture the final-cycle spike.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_load_i,
  output logic [W-1:0] sat_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    sat_o = (inc_i && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    cnt_d = clr_load_i ? '0 : sat_o;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-count decoder with snapshot, valid/ack handshake and muxed 8-bit readout.
// Optional SPIKE_DEC_TOTAL_EN adds a saturated all-channel total on sel=7.
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int unsigned N_CH     = N_CH_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  spike_rate_decoder_if.slave bus
);
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic                win_end;
  logic [CNT_W-1:0]    live_sat [N_CH];
  logic [CNT_W-1:0]    snap_q   [N_CH];
  logic [CNT_W-1:0]    rate_q, rate_d;
  logic                done_q;
  logic                ovr_q, ovr_d;
  hs_state_e           state_q, state_d;

  assign win_end = bus.ena && (win_q == '1);
  assign win_d   = bus.ena ? win_q + 1'b1 : win_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_i      (bus.ena & bus.spike_in[i]),
      .clr_load_i (win_end),
      .sat_o      (live_sat[i])
    );
  end

`ifdef SPIKE_DEC_TOTAL_EN
  logic [CNT_W-1:0] total_q;
  logic [CNT_W+2:0] sum;

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < N_CH; i++) sum = sum + (CNT_W+3)'(live_sat[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       total_q <= '0;
    else if (win_end) total_q <= (|sum[CNT_W+2:CNT_W]) ? '1 : sum[CNT_W-1:0];
  end
`endif

  always_comb begin
    rate_d = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (bus.sel == 3'(i)) rate_d = snap_q[i];
    end
`ifdef SPIKE_DEC_TOTAL_EN
    if (bus.sel == SEL_TOTAL) rate_d = total_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q  <= '0;
      done_q <= 1'b0;
      rate_q <= '0;
      ovr_q  <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) snap_q[i] <= '0;
    end else begin
      win_q  <= win_d;
      done_q <= win_end;
      rate_q <= rate_d;
      ovr_q  <= ovr_d;
      if (win_end) begin
        for (int unsigned i = 0; i < N_CH; i++) snap_q[i] <= live_sat[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A snapshot landing with an ack in the same cycle replaces the acked data cleanly.
  always_comb begin
    state_d = state_q;
    ovr_d   = ovr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_end) state_d = ST_VALID;
      end
      ST_VALID: begin
        if (win_end) begin
          if (!bus.rate_ack) ovr_d = 1'b1;
        end else if (bus.rate_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.rate_valid = (state_q == ST_VALID);
  end

  assign bus.rate_out    = rate_q;
  assign bus.window_done = done_q;
  assign bus.overrun     = ovr_q;
endmodule
